// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the MEM stage (master) and the data memory controller (slave).
interface data_memory_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic [1:0]  resp_cause;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_fault, resp_cause
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_fault, resp_cause
   );
endinterface

// File: rtl/data_memory_ctrl.sv
// Data memory with sub-word store merge, load extension, fault detection and
// a valid/ready request/response handshake with configurable access latency.
//
// state | meaning
// IDLE  | ready for a request (req_ready=1)
// WAIT  | access latency countdown, response data already registered
// RESP  | resp_valid=1, outputs held until resp_ready
module data_memory_ctrl #(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 1
) (
   input  logic             clk,
   input  logic             reset,
   data_memory_ctrl_if.slave bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic [31:0]   mem [DEPTH];

   logic          accept;
   logic          illegal, misaligned, out_of_range, fault;
   logic [1:0]    cause;
   logic [AW-1:0] idx;
   logic [31:0]   rd_word, merged, load_val;
   logic [7:0]    rd_byte;
   logic [15:0]   rd_half;

   assign bus.req_ready  = (state == IDLE);
   assign bus.resp_valid = (state == RESP);
   assign accept         = bus.req_valid && (state == IDLE);
   assign idx            = bus.req_addr[AW+1:2];
   assign rd_word        = mem[idx];
   assign fault          = (cause != 2'b00);

   always_comb begin
      illegal      = 1'b0;
      misaligned   = 1'b0;
      out_of_range = 1'b0;
      cause        = 2'b00;
      if (bus.req_we)
         illegal = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010});
      else
         illegal = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      misaligned   = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                     ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
      out_of_range = ({2'b00, bus.req_addr[31:2]} >= 32'(DEPTH));
      if (illegal)           cause = 2'b01;
      else if (misaligned)   cause = 2'b10;
      else if (out_of_range) cause = 2'b11;
   end

   // Store merge keeps untouched lanes; load extension selects the addressed lane.
   always_comb begin
      rd_byte = rd_word[{bus.req_addr[1:0], 3'b000} +: 8];
      rd_half = rd_word[{bus.req_addr[1], 4'b0000} +: 16];
      merged  = rd_word;
      case (bus.req_funct3[1:0])
         2'b00:   merged[{bus.req_addr[1:0], 3'b000} +: 8] = bus.req_wdata[7:0];
         2'b01:   merged[{bus.req_addr[1], 4'b0000} +: 16] = bus.req_wdata[15:0];
         default: merged = bus.req_wdata;
      endcase
      case (bus.req_funct3)
         3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
         3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
         3'b010:  load_val = rd_word;
         3'b100:  load_val = {24'h0, rd_byte};
         3'b101:  load_val = {16'h0, rd_half};
         default: load_val = 32'h0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset && accept && bus.req_we && !fault)
         mem[idx] <= merged;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= IDLE;
         cnt            <= '0;
         bus.resp_rdata <= 32'h0;
         bus.resp_fault <= 1'b0;
         bus.resp_cause <= 2'b00;
      end else begin
         state <= state_nxt;
         if (accept) begin
            cnt            <= CNT_LOAD;
            bus.resp_rdata <= (fault || bus.req_we) ? 32'h0 : load_val;
            bus.resp_fault <= fault;
            bus.resp_cause <= cause;
         end else if (state == WAIT) begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = (LATENCY > 1) ? WAIT : RESP;
         WAIT:    if (cnt <= CW'(1)) state_nxt = RESP;
         RESP:    if (bus.resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: one LATENCY=1 and one LATENCY=4 instance, scoreboard of expected responses.
module tb_data_memory_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        sel;
   logic        req_valid, req_we, resp_ready;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;

   data_memory_ctrl_if if_a();
   data_memory_ctrl_if if_b();

   assign if_a.req_valid  = req_valid & ~sel;
   assign if_b.req_valid  = req_valid & sel;
   assign if_a.resp_ready = resp_ready & ~sel;
   assign if_b.resp_ready = resp_ready & sel;
   assign if_a.req_we = req_we;         assign if_b.req_we = req_we;
   assign if_a.req_funct3 = req_funct3; assign if_b.req_funct3 = req_funct3;
   assign if_a.req_addr = req_addr;     assign if_b.req_addr = req_addr;
   assign if_a.req_wdata = req_wdata;   assign if_b.req_wdata = req_wdata;

   data_memory_ctrl #(.DEPTH(1024), .LATENCY(1)) dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
   data_memory_ctrl #(.DEPTH(1024), .LATENCY(4)) dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));

   logic        rr, rv, flt_o;
   logic [31:0] rdata_o;
   logic [1:0]  cause_o;
   assign rr      = sel ? if_b.req_ready  : if_a.req_ready;
   assign rv      = sel ? if_b.resp_valid : if_a.resp_valid;
   assign rdata_o = sel ? if_b.resp_rdata : if_a.resp_rdata;
   assign flt_o   = sel ? if_b.resp_fault : if_a.resp_fault;
   assign cause_o = sel ? if_b.resp_cause : if_a.resp_cause;

   typedef struct {logic [31:0] rd; logic f; logic [1:0] c;} exp_t;
   typedef struct {logic we; logic [2:0] f3; logic [31:0] addr; logic [31:0] wd;
                   logic [31:0] rd; logic f; logic [1:0] c;} step_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Drives one request, measures edges from acceptance to resp_valid, holds resp_ready low
   // for 'hold' cycles in RESP, then handshakes. held_ok is cleared if anything moved meanwhile.
   task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int hold,
                          output logic [31:0] rd, output logic flt, output logic [1:0] cs,
                          output int lat, output bit acc_ok, output bit held_ok, output bit to);
      @(negedge clk);
      acc_ok = rr;
      req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      req_valid = 1'b1; resp_ready = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0; req_we = ~we; req_funct3 = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      lat = 1; to = 1'b0; held_ok = 1'b1;
      while (!rv && lat < 40) begin
         if (rr) held_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      if (!rv) begin
         to = 1'b1; rd = 32'h0; flt = 1'b0; cs = 2'b00;
         return;
      end
      rd = rdata_o; flt = flt_o; cs = cause_o;
      if (rr) held_ok = 1'b0;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         if (!rv || rr || rdata_o !== rd || flt_o !== flt || cause_o !== cs) held_ok = 1'b0;
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      sel = 1'b0; req_valid = 1'b0; resp_ready = 1'b0; req_we = 1'b0;
      req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({if_a.req_ready, if_a.resp_valid, if_a.resp_rdata, if_a.resp_fault, if_a.resp_cause} !== {1'b1, 1'b0, 32'h0, 1'b0, 2'b00}) begin
         n_bad++;
         $display("FAIL reset_a: got ready=%b valid=%b rdata=%h fault=%b cause=%b, want 1 0 00000000 0 00",
                  if_a.req_ready, if_a.resp_valid, if_a.resp_rdata, if_a.resp_fault, if_a.resp_cause);
      end
      n_cmp++;
      if ({if_b.req_ready, if_b.resp_valid, if_b.resp_rdata, if_b.resp_fault, if_b.resp_cause} !== {1'b1, 1'b0, 32'h0, 1'b0, 2'b00}) begin
         n_bad++;
         $display("FAIL reset_b: got ready=%b valid=%b rdata=%h fault=%b cause=%b, want 1 0 00000000 0 00",
                  if_b.req_ready, if_b.resp_valid, if_b.resp_rdata, if_b.resp_fault, if_b.resp_cause);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_store_load();
      step_t t[9];
      exp_t e;
      logic [31:0] rd; logic flt; logic [1:0] cs; int lat; bit acc, held, to;
      t = '{'{1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 2'b00},
            '{1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 2'b00},
            '{1'b1, 3'b010, 32'hFFC, 32'hCAFEF00D, 32'h0,        1'b0, 2'b00},
            '{1'b0, 3'b010, 32'hFFC, 32'h0,        32'hCAFEF00D, 1'b0, 2'b00},
            '{1'b1, 3'b010, 32'h14,  32'h11223344, 32'h0,        1'b0, 2'b00},
            '{1'b1, 3'b001, 32'h16,  32'h9999ABCD, 32'h0,        1'b0, 2'b00},
            '{1'b0, 3'b001, 32'h16,  32'h0,        32'hFFFFABCD, 1'b0, 2'b00},
            '{1'b0, 3'b000, 32'h14,  32'h0,        32'h00000044, 1'b0, 2'b00},
            '{1'b0, 3'b010, 32'h14,  32'h0,        32'hABCD3344, 1'b0, 2'b00}};
      sel = 1'b0;
      foreach (t[i]) begin
         sb.push_back('{t[i].rd, t[i].f, t[i].c});
         run_req(t[i].we, t[i].f3, t[i].addr, t[i].wd, 0, rd, flt, cs, lat, acc, held, to);
         e = sb.pop_front();
         n_cmp++;
         if (to || rd !== e.rd || flt !== e.f || cs !== e.c) begin
            n_bad++;
            $display("FAIL store_load[%0d]: got rdata=%h fault=%b cause=%b timeout=%b, want rdata=%h fault=%b cause=%b",
                     i, rd, flt, cs, to, e.rd, e.f, e.c);
         end
         n_cmp++;
         if (!acc || lat !== 1) begin
            n_bad++;
            $display("FAIL store_load_lat[%0d]: got accepted=%b latency=%0d, want 1 and 1", i, acc, lat);
         end
      end
   endtask

   task automatic test_subword();
      step_t t[6];
      exp_t e;
      logic [31:0] rd; logic flt; logic [1:0] cs; int lat; bit acc, held, to;
      t = '{'{1'b1, 3'b000, 32'h12, 32'hAAAAAA7F, 32'h0,        1'b0, 2'b00},
            '{1'b0, 3'b010, 32'h10, 32'h0,        32'hDE7FBEEF, 1'b0, 2'b00},
            '{1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFFDE, 1'b0, 2'b00},
            '{1'b0, 3'b100, 32'h13, 32'h0,        32'h000000DE, 1'b0, 2'b00},
            '{1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFFDE7F, 1'b0, 2'b00},
            '{1'b0, 3'b101, 32'h10, 32'h0,        32'h0000BEEF, 1'b0, 2'b00}};
      sel = 1'b0;
      foreach (t[i]) begin
         sb.push_back('{t[i].rd, t[i].f, t[i].c});
         run_req(t[i].we, t[i].f3, t[i].addr, t[i].wd, 0, rd, flt, cs, lat, acc, held, to);
         e = sb.pop_front();
         n_cmp++;
         if (to || !acc || lat !== 1 || rd !== e.rd || flt !== e.f || cs !== e.c) begin
            n_bad++;
            $display("FAIL subword[%0d]: got rdata=%h fault=%b cause=%b lat=%0d acc=%b, want rdata=%h fault=%b cause=%b lat=1",
                     i, rd, flt, cs, lat, acc, e.rd, e.f, e.c);
         end
      end
   endtask

   task automatic test_faults();
      step_t t[14];
      exp_t e;
      logic [31:0] rd; logic flt; logic [1:0] cs; int lat; bit acc, held, to;
      t = '{'{1'b1, 3'b010, 32'h0,        32'h55AA55AA, 32'h0,        1'b0, 2'b00},
            '{1'b0, 3'b010, 32'h11,       32'h0,        32'h0,        1'b1, 2'b10},
            '{1'b1, 3'b001, 32'h13,       32'h0000FFFF, 32'h0,        1'b1, 2'b10},
            '{1'b0, 3'b010, 32'h10,       32'h0,        32'hDE7FBEEF, 1'b0, 2'b00},
            '{1'b0, 3'b011, 32'h10,       32'h0,        32'h0,        1'b1, 2'b01},
            '{1'b0, 3'b010, 32'h1000,     32'h0,        32'h0,        1'b1, 2'b11},
            '{1'b0, 3'b010, 32'hFFFFFFFC, 32'h0,        32'h0,        1'b1, 2'b11},
            '{1'b0, 3'b110, 32'h11,       32'h0,        32'h0,        1'b1, 2'b01},
            '{1'b0, 3'b001, 32'h1001,     32'h0,        32'h0,        1'b1, 2'b10},
            '{1'b1, 3'b010, 32'h1000,     32'h01010101, 32'h0,        1'b1, 2'b11},
            '{1'b1, 3'b100, 32'h10,       32'h02020202, 32'h0,        1'b1, 2'b01},
            '{1'b0, 3'b010, 32'h0,        32'h0,        32'h55AA55AA, 1'b0, 2'b00},
            '{1'b0, 3'b010, 32'h10,       32'h0,        32'hDE7FBEEF, 1'b0, 2'b00},
            '{1'b0, 3'b101, 32'h0FFE,     32'h0,        32'h0000CAFE, 1'b0, 2'b00}};
      sel = 1'b0;
      foreach (t[i]) begin
         sb.push_back('{t[i].rd, t[i].f, t[i].c});
         run_req(t[i].we, t[i].f3, t[i].addr, t[i].wd, 0, rd, flt, cs, lat, acc, held, to);
         e = sb.pop_front();
         n_cmp++;
         if (to || !acc || rd !== e.rd || flt !== e.f || cs !== e.c) begin
            n_bad++;
            $display("FAIL faults[%0d]: got rdata=%h fault=%b cause=%b acc=%b timeout=%b, want rdata=%h fault=%b cause=%b",
                     i, rd, flt, cs, acc, to, e.rd, e.f, e.c);
         end
      end
   endtask

   task automatic test_back_to_back();
      step_t t[4];
      int    hold[4];
      exp_t  e;
      logic [31:0] rd; logic flt; logic [1:0] cs; int lat; bit acc, held, to;
      t = '{'{1'b1, 3'b010, 32'h40, 32'h600DF00D, 32'h0,        1'b0, 2'b00},
            '{1'b0, 3'b010, 32'h40, 32'h0,        32'h600DF00D, 1'b0, 2'b00},
            '{1'b0, 3'b000, 32'h41, 32'h0,        32'hFFFFFFF0, 1'b0, 2'b00},
            '{1'b0, 3'b010, 32'h42, 32'h0,        32'h0,        1'b1, 2'b10}};
      hold = '{0, 3, 0, 2};
      sel = 1'b1;
      foreach (t[i]) begin
         sb.push_back('{t[i].rd, t[i].f, t[i].c});
         run_req(t[i].we, t[i].f3, t[i].addr, t[i].wd, hold[i], rd, flt, cs, lat, acc, held, to);
         e = sb.pop_front();
         n_cmp++;
         if (to || rd !== e.rd || flt !== e.f || cs !== e.c) begin
            n_bad++;
            $display("FAIL lat4[%0d]: got rdata=%h fault=%b cause=%b timeout=%b, want rdata=%h fault=%b cause=%b",
                     i, rd, flt, cs, to, e.rd, e.f, e.c);
         end
         n_cmp++;
         if (!acc || lat !== 4 || !held) begin
            n_bad++;
            $display("FAIL lat4_timing[%0d]: got accepted=%b latency=%0d held_stable=%b, want 1 4 1", i, acc, lat, held);
         end
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int   seen;
      logic [31:0] rd; logic flt; logic [1:0] cs; int lat; bit acc, held, to;
      sel = 1'b1;
      @(negedge clk);
      req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h12345678;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if ({rr, rv, rdata_o, flt_o, cause_o} !== {1'b1, 1'b0, 32'h0, 1'b0, 2'b00}) begin
         n_bad++;
         $display("FAIL reset_mid: got ready=%b valid=%b rdata=%h fault=%b cause=%b, want 1 0 00000000 0 00",
                  rr, rv, rdata_o, flt_o, cause_o);
      end
      @(negedge clk);
      reset = 1'b1;
      resp_ready = 1'b1;
      seen = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (rv) seen++;
      end
      resp_ready = 1'b0;
      n_cmp++;
      if (seen !== 0) begin
         n_bad++;
         $display("FAIL reset_mid_noresp: got %0d resp_valid cycles, want 0", seen);
      end
      sb.push_back('{32'h12345678, 1'b0, 2'b00});
      run_req(1'b0, 3'b010, 32'h20, 32'h0, 0, rd, flt, cs, lat, acc, held, to);
      e = sb.pop_front();
      n_cmp++;
      if (to || !acc || rd !== e.rd || flt !== e.f || cs !== e.c) begin
         n_bad++;
         $display("FAIL reset_mid_load: got rdata=%h fault=%b cause=%b acc=%b timeout=%b, want rdata=%h fault=0 cause=00",
                  rd, flt, cs, acc, to, e.rd);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_store_load();
      test_subword();
      test_faults();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
